seq_addsub: RTL and testbench

Parametrised multi-cycle adder/subtractor succeeding the 32-bit combinational subtractor in the arithmetic library. Operands are processed DIGIT bits per cycle through one shared digit adder, with a start/busy/done handshake, unsigned carry/borrow, signed overflow and zero flags. It sits between the datapath register file and result writeback wherever area matters more than single-cycle latency.

---
 rtl/addsub_pkg.sv | 24 ++
 rtl/addsub_digit.sv | 27 ++
 rtl/seq_addsub.sv | 136 +++++++++++++
 tb/tb_seq_addsub.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and constants for the sequential adder/subtractor.
// Saturation limits are only used when ADDSUB_SAT_EN is defined.
package addsub_pkg;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Widest operand the saturation helpers can describe; callers cast down to their width.
    localparam int unsigned SAT_MAX_W = 1024;

    function automatic logic [SAT_MAX_W-1:0] sat_max(input int unsigned width);
        return (SAT_MAX_W'(1) << (width - 1)) - SAT_MAX_W'(1);
    endfunction

    function automatic logic [SAT_MAX_W-1:0] sat_min(input int unsigned width);
        return SAT_MAX_W'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/addsub_digit.sv
// DIGIT-bit ripple-carry adder slice shared by every step of seq_addsub.
// c_msb is the carry into the top bit, needed for signed overflow on the final digit.
module addsub_digit #(
    parameter int unsigned DIGIT = 8
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             cin,
    output logic [DIGIT-1:0] s_d,
    output logic             cout,
    output logic             c_msb
);

    always_comb begin
        logic c;
        c     = cin;
        c_msb = cin;
        s_d   = '0;
        for (int i = 0; i < int'(DIGIT); i++) begin
            if (i == int'(DIGIT) - 1) c_msb = c;
            s_d[i] = a_d[i] ^ b_d[i] ^ c;
            c      = (a_d[i] & b_d[i]) | (c & (a_d[i] ^ b_d[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands processed DIGIT bits per cycle.
// Define ADDSUB_SAT_EN to clamp the result to the signed limits on overflow.
module seq_addsub
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned N      = WIDTH / DIGIT;
    localparam int unsigned IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned BASE_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    if (DIGIT == 0 || DIGIT > WIDTH) begin : g_bad_digit
        $error("seq_addsub: DIGIT must satisfy 1 <= DIGIT <= WIDTH");
    end
    if (WIDTH % DIGIT != 0) begin : g_bad_width
        $error("seq_addsub: WIDTH must be a multiple of DIGIT");
    end

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic             carry_q;
    logic             op_q;

    logic [BASE_W-1:0] base;
    logic [DIGIT-1:0]  a_d;
    logic [DIGIT-1:0]  b_d;
    logic [DIGIT-1:0]  s_d;
    logic              cout;
    logic              c_msb;
    logic [WIDTH-1:0]  sum_full;
    logic [WIDTH-1:0]  final_res;
    logic              ovf;

    assign base = BASE_W'(idx_q * DIGIT);
    assign a_d  = a_q[base +: DIGIT];
    assign b_d  = b_q[base +: DIGIT];

    addsub_digit #(
        .DIGIT(DIGIT)
    ) u_digit (
        .a_d  (a_d),
        .b_d  (b_d),
        .cin  (carry_q),
        .s_d  (s_d),
        .cout (cout),
        .c_msb(c_msb)
    );

    // Full result as it will look once the current digit lands; only consumed on the last digit.
    always_comb begin
        sum_full = acc_q;
        sum_full[base +: DIGIT] = s_d;
    end

    assign ovf = c_msb ^ cout;

`ifdef ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] SAT_HI = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SAT_LO = WIDTH'(sat_min(WIDTH));

    // A wrapped negative MSB on overflow means the true result was positive.
    assign final_res = ovf ? (sum_full[WIDTH-1] ? SAT_HI : SAT_LO) : sum_full;
`else
    assign final_res = sum_full;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            carry_q   <= 1'b0;
            op_q      <= OP_ADD;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= (op == OP_SUB) ? ~b : b;
                        carry_q <= op;
                        op_q    <= op;
                        idx_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q[base +: DIGIT] <= s_d;
                    carry_q              <= cout;
                    if (idx_q == LAST_IDX) begin
                        state_q   <= IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        result    <= final_res;
                        // Final carry of a + ~b + 1 is the inverse of the borrow.
                        carry_out <= (op_q == OP_SUB) ? ~cout : cout;
                        overflow  <= ovf;
                        zero      <= (final_res == '0);
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_addsub.sv
// Self-checking bench for seq_addsub: three 32-bit instances with DIGIT = 8, 1 and 32.
// Honours ADDSUB_SAT_EN so the expected results match the build under test.
module tb_seq_addsub;

    localparam int unsigned W = 32;
`ifdef ADDSUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          start_v [3];
    logic          op_v    [3];
    logic [W-1:0]  a_v     [3];
    logic [W-1:0]  b_v     [3];
    logic          busy_v  [3];
    logic          done_v  [3];
    logic [W-1:0]  res_v   [3];
    logic          co_v    [3];
    logic          ov_v    [3];
    logic          z_v     [3];

    int errors = 0;
    int checks = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        seq_addsub #(
            .WIDTH(W),
            .DIGIT((g == 0) ? 8 : ((g == 1) ? 1 : 32))
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .start    (start_v[g]),
            .op       (op_v[g]),
            .a        (a_v[g]),
            .b        (b_v[g]),
            .busy     (busy_v[g]),
            .done     (done_v[g]),
            .result   (res_v[g]),
            .carry_out(co_v[g]),
            .overflow (ov_v[g]),
            .zero     (z_v[g])
        );
    end

    function automatic int n_of(input int g);
        return (g == 0) ? 4 : ((g == 1) ? 32 : 1);
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference model: true signed/unsigned arithmetic on 64-bit integers.
    task automatic model(input bit o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] r, output logic co, output logic ov,
                         output logic z);
        longint          sx, sy, t;
        longint unsigned ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'(x);
        uy = longint'(y);
        t  = o ? (sx - sy) : (sx + sy);
        ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
        co = o ? (ux < uy) : ((ux + uy) > 64'hFFFF_FFFF);
        r  = t[W-1:0];
        if (SAT && ov) r = (t > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        z  = (r == '0);
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that raised done.
    task automatic check_op(input string nm, input int g, input bit o,
                            input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic [W-1:0] er, input logic eco, input logic eov,
                            input logic ez);
        int lat;
        op_v[g]    = o;
        a_v[g]     = x;
        b_v[g]     = y;
        start_v[g] = 1'b1;
        @(posedge clk);
        #1;
        start_v[g] = 1'b0;
        chk({nm, " busy_after_start"}, busy_v[g], 1);
        lat = 0;
        while (done_v[g] !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, " latency"}, lat, n_of(g));
        chk({nm, " busy_at_done"}, busy_v[g], 0);
        chk({nm, " result"}, res_v[g], er);
        chk({nm, " carry_out"}, co_v[g], eco);
        chk({nm, " overflow"}, ov_v[g], eov);
        chk({nm, " zero"}, z_v[g], ez);
    endtask

    function automatic logic [W-1:0] rnd_operand();
        unique case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return W'($urandom);
        endcase
    endfunction

    typedef struct {
        string        nm;
        bit           op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         co;
        logic         ov;
        logic         z;
    } vec_t;

    initial begin
        vec_t         vecs [$];
        logic [W-1:0] er;
        logic         eco, eov, ez;
        int           pulses;

        for (int g = 0; g < 3; g++) begin
            start_v[g] = 1'b0;
            op_v[g]    = 1'b0;
            a_v[g]     = '0;
            b_v[g]     = '0;
        end

        vecs.push_back('{"sub_1200_1100", 1'b1, 32'd1200, 32'd1100, 32'd100, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"sub_borrow", 1'b1, 32'h1, 32'h10, 32'hFFFF_FFF1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"sub_equal", 1'b1, 32'h10, 32'h10, 32'h0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"add_pos_ovf", 1'b0, 32'h7FFF_FFFF, 32'h1,
                         SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"sub_neg_ovf", 1'b1, 32'h8000_0000, 32'h1,
                         SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"add_wrap_zero", 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{"add_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000,
                         SAT ? 32'h8000_0000 : 32'h0, 1'b1, 1'b1, !SAT});
        vecs.push_back('{"sub_zero_zero", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"sub_0_min", 1'b1, 32'h0, 32'h8000_0000,
                         SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b1, 1'b1, 1'b0});

        // Reset state on every instance.
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            chk("reset busy", busy_v[g], 0);
            chk("reset done", done_v[g], 0);
            chk("reset result", res_v[g], 0);
            chk("reset carry_out", co_v[g], 0);
            chk("reset overflow", ov_v[g], 0);
            chk("reset zero", z_v[g], 0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed vectors, issued back-to-back on the done cycle.
        foreach (vecs[i])
            check_op(vecs[i].nm, 0, vecs[i].op, vecs[i].a, vecs[i].b,
                     vecs[i].res, vecs[i].co, vecs[i].ov, vecs[i].z);

        // Start pulses while busy must be ignored.
        op_v[0] = 1'b1; a_v[0] = 32'd1200; b_v[0] = 32'd1100; start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            op_v[0] = i[0];
            a_v[0]  = W'($urandom);
            b_v[0]  = W'($urandom);
            @(posedge clk);
            #1;
        end
        start_v[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("ignore done", done_v[0], 1);
        chk("ignore result", res_v[0], 32'd100);
        @(posedge clk);
        #1;
        chk("done one cycle", done_v[0], 0);
        chk("no queued op", busy_v[0], 0);

        // Reset in the middle of an operation aborts it with no done pulse.
        op_v[0] = 1'b0; a_v[0] = 32'd5; b_v[0] = 32'd6; start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort busy", busy_v[0], 0);
        chk("abort result", res_v[0], 0);
        chk("abort done", done_v[0], 0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done_v[0] === 1'b1) pulses++;
        end
        chk("abort no done pulse", pulses, 0);
        check_op("after_abort", 0, 1'b0, 32'd5, 32'd6, 32'd11, 1'b0, 1'b0, 1'b0);

        // Random vectors against the reference model on every instance.
        for (int g = 0; g < 3; g++) begin
            int cnt;
            cnt = (g == 0) ? 300 : 1000;
            for (int i = 0; i < cnt; i++) begin
                bit           o;
                logic [W-1:0] x, y;
                o = 1'($urandom_range(0, 1));
                x = rnd_operand();
                y = rnd_operand();
                model(o, x, y, er, eco, eov, ez);
                check_op($sformatf("rnd_d%0d", n_of(g)), g, o, x, y, er, eco, eov, ez);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
